// File: rtl/shift_serializer.sv
// shift_serializer
// ----------------
// Parallel-to-serial converter. A WIDTH-bit word is taken on a load_valid /
// load_ready handshake and sent MSB first on ser_data. Each bit is held for
// BIT_DIV clk cycles, and ser_enable strobes in the last cycle of each bit
// period. A downstream left-shifting receiver clocked on ser_enable
// therefore holds the complete word after WIDTH strobes.
//
// Handshake: a word is accepted on any rising clk edge where load_valid and
// load_ready are both 1. load_data is sampled on that edge only and is
// ignored at all other times. load_ready depends only on the state and the
// counters, never on load_valid. It is 1 in IDLE and in the final cycle of
// the bit-0 period, so a new word can follow the current one with no gap.
//
// Ports:
//   clk         clock, rising edge
//   reset_n     asynchronous active-low reset
//   load_valid  upstream word available on load_data
//   load_data   parallel word to transmit (WIDTH bits)
//   load_ready  block can accept a word this cycle
//   ser_data    serial bit, MSB first (0 while idle)
//   ser_enable  strobe: ser_data valid for downstream shift-in this cycle
//   busy        word in transmission
//   done        one-cycle pulse in the cycle after the bit-0 strobe
//   state_dbg   current FSM state (0 = IDLE, 1 = SHIFT)

module shift_serializer #(
    parameter int WIDTH   = 8,
    parameter int BIT_DIV = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_data,
    output logic             ser_enable,
    output logic             busy,
    output logic             done,
    output logic             state_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BIT_W = $clog2(WIDTH);
    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    // A bit period of one cycle means its first cycle is also its strobe cycle.
    localparam logic EN_ON_FIRST = (BIT_DIV == 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
    logic             ser_data_nxt;
    logic             ser_enable_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             last_cycle;
    logic             accept;

    // Final cycle of the bit-0 period of the current word.
    assign last_cycle = (state == SHIFT) && (bit_cnt == BIT_LAST) && (div_cnt == DIV_LAST);
    assign load_ready = (state == IDLE) || last_cycle;
    assign accept     = load_valid && load_ready;
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            ser_data   <= 1'b0;
            ser_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            div_cnt    <= div_cnt_nxt;
            ser_data   <= ser_data_nxt;
            ser_enable <= ser_enable_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

    // shreg[WIDTH-1] is always the bit currently on ser_data. The registered
    // outputs are computed one cycle ahead, so the next bit is taken from
    // shreg[WIDTH-2] at the same time as the shift.
    always_comb begin
        state_nxt      = state;
        shreg_nxt      = shreg;
        bit_cnt_nxt    = bit_cnt;
        div_cnt_nxt    = div_cnt;
        ser_data_nxt   = ser_data;
        ser_enable_nxt = 1'b0;
        busy_nxt       = busy;
        // done follows the last strobe whether or not a new word is accepted.
        done_nxt       = last_cycle;

        if (accept) begin
            state_nxt      = SHIFT;
            shreg_nxt      = load_data;
            bit_cnt_nxt    = '0;
            div_cnt_nxt    = '0;
            ser_data_nxt   = load_data[WIDTH-1];
            ser_enable_nxt = EN_ON_FIRST;
            busy_nxt       = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    ser_data_nxt = 1'b0;
                    busy_nxt     = 1'b0;
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt_nxt = '0;
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt    = IDLE;
                            shreg_nxt    = '0;
                            bit_cnt_nxt  = '0;
                            ser_data_nxt = 1'b0;
                            busy_nxt     = 1'b0;
                        end else begin
                            bit_cnt_nxt    = bit_cnt + 1'b1;
                            shreg_nxt      = {shreg[WIDTH-2:0], 1'b0};
                            ser_data_nxt   = shreg[WIDTH-2];
                            ser_enable_nxt = EN_ON_FIRST;
                        end
                    end else begin
                        div_cnt_nxt    = div_cnt + 1'b1;
                        ser_enable_nxt = ((div_cnt + 1'b1) == DIV_LAST);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
